// File: rtl/wptr_full_ctrl_if.sv
// Write-side bus of the async FIFO pointer controller: user handshake,
// synchronized read pointer in, RAM write port and status flags out.
interface wptr_full_ctrl_if #(
    parameter int unsigned ADDR_SIZE = 6
);
    logic                 w_inc;
    logic [ADDR_SIZE:0]   syn_rptr;
    logic                 w_ovf_clr;
    logic                 w_en;
    logic [ADDR_SIZE-1:0] waddr;
    logic [ADDR_SIZE:0]   wptr;
    logic                 w_full;
    logic                 w_afull;
    logic [ADDR_SIZE:0]   w_level;
    logic                 w_ovf;

    // Write-side user logic / synchronizer side
    modport master (
        output w_inc, syn_rptr, w_ovf_clr,
        input  w_en, waddr, wptr, w_full, w_afull, w_level, w_ovf
    );

    // Pointer controller side
    modport slave (
        input  w_inc, syn_rptr, w_ovf_clr,
        output w_en, waddr, wptr, w_full, w_afull, w_level, w_ovf
    );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and status controller for the asynchronous FIFO.
// Owns the binary write address and Gray write pointer, and derives full,
// almost-full, occupancy and sticky overflow from the synchronized read pointer.
module wptr_full_ctrl #(
    parameter int unsigned ADDR_SIZE    = 6,
    parameter int unsigned AFULL_THRESH = 60
) (
    input logic              w_clk,
    input logic              w_rst,
    wptr_full_ctrl_if.slave  bus
);
    localparam int unsigned PW = ADDR_SIZE + 1;

    logic [PW-1:0] wbin;
    logic [PW-1:0] wptr_reg;
    logic [PW-1:0] level_reg;
    logic          full_reg;
    logic          afull_reg;
    logic          ovf_reg;

    logic          w_en;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rptr_wrapped;
    logic [PW-1:0] level_next;
    logic          full_next;
    logic          afull_next;

    // Writes are gated by the registered full flag, so a full FIFO never accepts
    assign w_en = bus.w_inc & ~full_reg;

    // Next-pointer, Gray decode of the read pointer, and status arithmetic
    always_comb begin
        wbin_next    = wbin + PW'(w_en);
        wgray_next   = (wbin_next >> 1) ^ wbin_next;
        rbin         = '0;
        for (int i = 0; i < int'(PW); i++) begin
            rbin[i] = ^(bus.syn_rptr >> i);
        end
        // Full when the write pointer is exactly one lap ahead of the read pointer
        rptr_wrapped = {~bus.syn_rptr[PW-1:PW-2], bus.syn_rptr[PW-3:0]};
        full_next    = (wgray_next == rptr_wrapped);
        level_next   = wbin_next - rbin;
        afull_next   = (level_next >= PW'(AFULL_THRESH));
    end

    // Pointer and status registers; reset discards the pointer without flagging overflow
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            wbin      <= '0;
            wptr_reg  <= '0;
            full_reg  <= 1'b0;
            afull_reg <= 1'b0;
            level_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            wbin      <= wbin_next;
            wptr_reg  <= wgray_next;
            full_reg  <= full_next;
            afull_reg <= afull_next;
            level_reg <= level_next;
            // Set beats clear when both happen in one cycle
            if (bus.w_inc & full_reg) begin
                ovf_reg <= 1'b1;
            end else if (bus.w_ovf_clr) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    assign bus.w_en    = w_en;
    assign bus.waddr   = wbin[ADDR_SIZE-1:0];
    assign bus.wptr    = wptr_reg;
    assign bus.w_full  = full_reg;
    assign bus.w_afull = afull_reg;
    assign bus.w_level = level_reg;
    assign bus.w_ovf   = ovf_reg;
endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl: directed plan steps followed by
// randomized write/read-pointer traffic against an occupancy-count model.
module tb_wptr_full_ctrl;
    localparam int unsigned ADDR_SIZE = 6;
    localparam int          DEPTH     = 64;
    localparam int          AFULL     = 60;

    logic w_clk = 1'b0;
    logic w_rst;

    wptr_full_ctrl_if #(.ADDR_SIZE(ADDR_SIZE)) bus ();

    wptr_full_ctrl #(
        .ADDR_SIZE   (ADDR_SIZE),
        .AFULL_THRESH(AFULL)
    ) dut (
        .w_clk(w_clk),
        .w_rst(w_rst),
        .bus  (bus)
    );

    always #5 w_clk = ~w_clk;

    // Model state: total accepted writes and the read count seen through the synchronizer
    int m_wr;
    int m_sr;
    int m_level;
    bit m_full;
    bit m_afull;
    bit m_ovf;

    int n_checks;
    int n_pass;

    function automatic logic [6:0] to_gray(input int v);
        logic [6:0] b;
        b = 7'(v % 128);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock cycle: drive inputs, check combinational outputs, then registered outputs
    task automatic cycle(input bit inc, input bit clr, input bit rst, input int sr);
        bit exp_en;
        bit old_full;
        bus.w_inc     = inc;
        bus.w_ovf_clr = clr;
        w_rst         = rst;
        m_sr          = sr;
        bus.syn_rptr  = to_gray(sr);
        #1;
        exp_en = inc && !m_full;
        check("w_en", 32'(bus.w_en), 32'(exp_en));
        check("waddr_pre", 32'(bus.waddr), 32'(m_wr % DEPTH));
        @(posedge w_clk);
        old_full = m_full;
        if (rst) begin
            m_wr = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
        end else begin
            if (exp_en) m_wr++;
            m_level = m_wr - m_sr;
            m_full  = (m_level == DEPTH);
            m_afull = (m_level >= AFULL);
            if (inc && old_full) m_ovf = 1;
            else if (clr)        m_ovf = 0;
        end
        #1;
        check("waddr",   32'(bus.waddr),   32'(m_wr % DEPTH));
        check("wptr",    32'(bus.wptr),    32'(to_gray(m_wr)));
        check("w_full",  32'(bus.w_full),  32'(m_full));
        check("w_afull", 32'(bus.w_afull), 32'(m_afull));
        check("w_level", 32'(bus.w_level), 32'(m_level));
        check("w_ovf",   32'(bus.w_ovf),   32'(m_ovf));
    endtask

    initial begin
        logic [6:0] wptr_hold;
        n_checks = 0; n_pass = 0;
        m_wr = 0; m_sr = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
        bus.w_inc = 1'b0; bus.w_ovf_clr = 1'b0; bus.syn_rptr = '0; w_rst = 1'b1;

        // Reset held two cycles with writes requested
        cycle(1, 0, 1, 0);
        cycle(1, 0, 1, 0);
        check("rst_waddr", 32'(bus.waddr), 32'd0);
        check("rst_level", 32'(bus.w_level), 32'd0);

        // Fill: 64 writes reach full
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 0);
        check("fill_full",  32'(bus.w_full),  32'd1);
        check("fill_level", 32'(bus.w_level), 32'd64);
        check("fill_waddr", 32'(bus.waddr),   32'd0);
        check("fill_wptr",  32'(bus.wptr),    32'b1100000);
        wptr_hold = bus.wptr;
        // 65th request is blocked and flags overflow
        cycle(1, 0, 0, 0);
        check("blk_wptr", 32'(bus.wptr),  32'(wptr_hold));
        check("blk_ovf",  32'(bus.w_ovf), 32'd1);

        // Clear with a simultaneous overflowing write: set wins
        cycle(1, 1, 0, 0);
        check("clr_set_wins", 32'(bus.w_ovf), 32'd1);
        cycle(0, 1, 0, 0);
        check("clr_alone", 32'(bus.w_ovf), 32'd0);

        // Drain one slot: that cycle's write stays blocked, next one refills
        cycle(1, 0, 0, 1);
        check("drain_full",  32'(bus.w_full),  32'd0);
        check("drain_level", 32'(bus.w_level), 32'd63);
        cycle(1, 0, 0, 1);
        check("refill_full", 32'(bus.w_full), 32'd1);
        cycle(0, 0, 0, 1);

        // Almost-full threshold
        cycle(0, 0, 1, 0);
        for (int i = 0; i < AFULL - 1; i++) cycle(1, 0, 0, 0);
        check("af59_afull", 32'(bus.w_afull), 32'd0);
        check("af59_level", 32'(bus.w_level), 32'd59);
        cycle(1, 0, 0, 0);
        check("af60_afull", 32'(bus.w_afull), 32'd1);
        check("af60_level", 32'(bus.w_level), 32'd60);

        // Wrap: read pointer trails so occupancy settles at 4 through pointer wrap
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 200; i++) cycle(1, 0, 0, (m_wr >= 3) ? m_wr - 3 : 0);
        check("wrap_level", 32'(bus.w_level), 32'd4);
        check("wrap_full",  32'(bus.w_full),  32'd0);

        // Randomized traffic at several read rates with occasional reset and clear
        cycle(0, 0, 1, 0);
        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < 500; i++) begin
                bit inc, clr, rst;
                int sr;
                inc = ($urandom_range(0, 9) < 8);
                clr = ($urandom_range(0, 19) == 0);
                rst = ($urandom_range(0, 299) == 0);
                sr  = m_sr;
                if ($urandom_range(0, 9) < blk * 2) sr = sr + int'($urandom_range(1, 2));
                if (sr > m_wr) sr = m_wr;
                if (rst) sr = 0;
                cycle(inc, clr, rst, sr);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
